// File: rtl/radar_pkg.sv
// Shared constants and FSM encoding for the radar feature-map datapath.
package radar_pkg;

  localparam int FRAME_LEN_DEF = 16384;
  localparam int BIN_CNT_W     = 17;
  localparam int WORD_W_DEF    = 32;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PACK = 1'b1
  } state_t;

endpackage

// File: rtl/word_fifo2.sv
// Two-entry in-order FIFO; a push while full without a pop is dropped and
// reported on the combinational ovf_pulse output.
module word_fifo2 #(
  parameter int DW = 42
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic          empty,
  output logic [DW-1:0] head,
  output logic          ovf_pulse
);

  logic [DW-1:0] head_r;
  logic [DW-1:0] tail_r;
  logic [1:0]    cnt_r;
  logic          full_s;
  logic          pop_s;

  assign full_s    = (cnt_r == 2'd2);
  assign empty     = (cnt_r == 2'd0);
  assign pop_s     = pop & ~empty;
  assign head      = head_r;
  assign ovf_pulse = push & full_s & ~pop_s;

  // Storage and occupancy update; head_r always holds the oldest entry.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      head_r <= '0;
      tail_r <= '0;
      cnt_r  <= 2'd0;
    end else begin
      case ({push, pop_s})
        2'b10: begin
          case (cnt_r)
            2'd0: begin
              head_r <= push_data;
              cnt_r  <= 2'd1;
            end
            2'd1: begin
              tail_r <= push_data;
              cnt_r  <= 2'd2;
            end
            default: begin
              cnt_r <= cnt_r;
            end
          endcase
        end
        2'b01: begin
          head_r <= tail_r;
          cnt_r  <= cnt_r - 2'd1;
        end
        2'b11: begin
          if (full_s) begin
            head_r <= tail_r;
            tail_r <= push_data;
          end else begin
            head_r <= push_data;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

endmodule

// File: rtl/bin_word_packer.sv
// Packs 1-bit comparator decisions LSB-first into WW-bit words tagged with
// word address and end-of-frame, buffered by a 2-entry FIFO.
module bin_word_packer
  import radar_pkg::*;
#(
  parameter int WW        = WORD_W_DEF,
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int AW        = 9
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iCLR,
  input  logic          iEN,
  input  logic          iDATA,
  output logic          oVALID,
  input  logic          iREADY,
  output logic [WW-1:0] oDATA,
  output logic [AW-1:0] oADDR,
  output logic          oLAST,
  output logic          oOVF,
  output logic          oBUSY
);

  localparam int BW    = $clog2(WW);
  localparam int WORDS = (FRAME_LEN + WW - 1) / WW;
  localparam int DW    = WW + AW + 1;
  localparam logic [BIN_CNT_W-1:0] LAST_BIN = BIN_CNT_W'(FRAME_LEN - 1);
  localparam logic [BW-1:0]        LAST_BIT = BW'(WW - 1);

  if ((2 ** AW) < WORDS) begin : g_aw_check
    $error("bin_word_packer: AW too small to address every word of a frame");
  end

  state_t               state_r;
  state_t               state_nxt_s;
  logic [WW-1:0]        shift_r;
  logic [BW-1:0]        bit_cnt_r;
  logic [BIN_CNT_W-1:0] frame_cnt_r;
  logic [AW-1:0]        addr_r;
  logic                 ovf_r;

  logic                 accept_s;
  logic                 last_s;
  logic                 complete_s;
  logic [WW-1:0]        word_s;
  logic [DW-1:0]        push_data_s;
  logic [DW-1:0]        head_s;
  logic                 fifo_empty_s;
  logic                 fifo_ovf_s;

  assign accept_s = iEN & ~iCLR;

  // Word under construction with the incoming bit merged, plus completion flags.
  always_comb begin
    word_s            = shift_r;
    word_s[bit_cnt_r] = iDATA;
    last_s            = (frame_cnt_r == LAST_BIN);
    complete_s        = accept_s & (last_s | (bit_cnt_r == LAST_BIT));
    push_data_s       = {word_s, addr_r, last_s};
  end

  // FSM state register.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: a frame is in progress between its first and last bit.
  always_comb begin
    state_nxt_s = state_r;
    if (iCLR) begin
      state_nxt_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s && !last_s) begin
            state_nxt_s = S_PACK;
          end else begin
            state_nxt_s = S_IDLE;
          end
        end
        S_PACK: begin
          if (accept_s && last_s) begin
            state_nxt_s = S_IDLE;
          end else begin
            state_nxt_s = S_PACK;
          end
        end
        default: begin
          state_nxt_s = S_IDLE;
        end
      endcase
    end
  end

  // Shift register, counters and address; the last word rewinds them to 0.
  always_ff @(posedge iCLK) begin
    if (iRST || iCLR) begin
      shift_r     <= '0;
      bit_cnt_r   <= '0;
      frame_cnt_r <= '0;
      addr_r      <= '0;
    end else if (accept_s) begin
      if (complete_s) begin
        shift_r   <= '0;
        bit_cnt_r <= '0;
        if (last_s) begin
          frame_cnt_r <= '0;
          addr_r      <= '0;
        end else begin
          frame_cnt_r <= frame_cnt_r + BIN_CNT_W'(1);
          addr_r      <= addr_r + AW'(1);
        end
      end else begin
        shift_r     <= word_s;
        bit_cnt_r   <= bit_cnt_r + BW'(1);
        frame_cnt_r <= frame_cnt_r + BIN_CNT_W'(1);
      end
    end else begin
      shift_r <= shift_r;
    end
  end

  // Sticky overflow flag, cleared only by reset or frame abort.
  always_ff @(posedge iCLK) begin
    if (iRST || iCLR) begin
      ovf_r <= 1'b0;
    end else if (fifo_ovf_s) begin
      ovf_r <= 1'b1;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  word_fifo2 #(.DW(DW)) u_fifo (
    .clk       (iCLK),
    .rst       (iRST),
    .clr       (iCLR),
    .push      (complete_s),
    .push_data (push_data_s),
    .pop       (iREADY),
    .empty     (fifo_empty_s),
    .head      (head_s),
    .ovf_pulse (fifo_ovf_s)
  );

  assign {oDATA, oADDR, oLAST} = head_s;
  assign oVALID = ~fifo_empty_s;
  assign oOVF   = ovf_r;
  assign oBUSY  = (state_r == S_PACK);

endmodule
